// File: rtl/joy_pad.sv
// Sega Mega Drive gamepad, device side: answers TH select cycles from a 12-bit button vector.
// Build with JOY_PAD_SIX_BUTTON_EN defined for the 6-button pad; undefined gives a 3-button pad.
module joy_pad #(
  parameter int TIMEOUT_CYCLES = 37500
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        th,
  input  logic [11:0] buttons,
  output logic        d1,
  output logic        d2,
  output logic        d3,
  output logic        d4,
  output logic        d6,
  output logic        d9,
  output logic [2:0]  phase
);

  logic       r_th_s1;
  logic       r_th_s2;
  logic       r_th_prev;
  logic       w_fall;
  logic       w_edge;
  logic [2:0] w_f_next;
  logic [5:0] w_d;
  logic [5:0] r_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_th_s1   <= 1'b1;
      r_th_s2   <= 1'b1;
      r_th_prev <= 1'b1;
    end else begin
      r_th_s1   <= th;
      r_th_s2   <= r_th_s1;
      r_th_prev <= r_th_s2;
    end
  end

  assign w_fall = r_th_prev & ~r_th_s2;
  assign w_edge = r_th_prev ^ r_th_s2;

`ifdef JOY_PAD_SIX_BUTTON_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_idle;
  logic [2:0]    r_f;
  logic          w_timeout;

  // Timeout fires on the clock the idle count steps onto its last value.
  assign w_timeout = (r_idle >= IDLE_MAX - 1'b1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_idle <= '0;
    end else if (w_edge) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_MAX) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_f <= 3'd0;
    end else begin
      r_f <= w_f_next;
    end
  end

  always_comb begin
    w_f_next = r_f;
    if (w_fall) begin
      w_f_next = (r_f == 3'd4) ? 3'd1 : r_f + 3'd1;
    end else if (!w_edge && w_timeout) begin
      w_f_next = 3'd0;
    end
  end

  assign phase = r_f;
`else
  assign w_f_next = 3'd0;
  assign phase    = 3'd0;
`endif

  // Output mux uses the post-edge count so a pin never shows the previous phase's row.
  always_comb begin
    w_d = {~buttons[0], ~buttons[1], ~buttons[2], ~buttons[3], ~buttons[5], ~buttons[6]};
    if (r_th_s2) begin
      if (w_f_next == 3'd3) begin
        w_d = {~buttons[8], ~buttons[9], ~buttons[10], ~buttons[11], ~buttons[5], ~buttons[6]};
      end
    end else begin
      case (w_f_next)
        3'd3:    w_d = {4'b0000, ~buttons[4], ~buttons[7]};
        3'd4:    w_d = {4'b1111, ~buttons[4], ~buttons[7]};
        default: w_d = {~buttons[0], ~buttons[1], 2'b00, ~buttons[4], ~buttons[7]};
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_d <= 6'b111111;
    end else begin
      r_d <= w_d;
    end
  end

  assign {d1, d2, d3, d4, d6, d9} = r_d;

endmodule

// File: tb/tb_joy_pad.sv
// Self-checking bench for joy_pad: vector table, directed TH sequences, random run vs reference model.
module tb_joy_pad;
  localparam int T = 100;
`ifdef JOY_PAD_SIX_BUTTON_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        th = 1'b1;
  logic [11:0] buttons = 12'h000;
  logic        d1, d2, d3, d4, d6, d9;
  logic [2:0]  phase;
  logic [5:0]  dut_d;
  int          errors = 0;
  int          checks = 0;

  joy_pad #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .th(th), .buttons(buttons),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d6(d6), .d9(d9), .phase(phase)
  );

  always #5 clock = ~clock;
  assign dut_d = {d1, d2, d3, d4, d6, d9};

  // Pin levels {d1,d2,d3,d4,d6,d9} straight from the pad's output table.
  function automatic logic [5:0] pad_levels(input logic ths, input int f, input logic [11:0] b);
    if (ths) begin
      if (f == 3) return {~b[8], ~b[9], ~b[10], ~b[11], ~b[5], ~b[6]};
      return {~b[0], ~b[1], ~b[2], ~b[3], ~b[5], ~b[6]};
    end
    if (f == 3) return {4'b0000, ~b[4], ~b[7]};
    if (f == 4) return {4'b1111, ~b[4], ~b[7]};
    return {~b[0], ~b[1], 2'b00, ~b[4], ~b[7]};
  endfunction

  // Reference: th seen two clocks late, count of falls, clocks since the last seen edge.
  logic       m_hist [3];
  int         m_f;
  int         m_quiet;
  logic [5:0] m_d;
  always @(posedge clock) begin
    logic ths, prev;
    if (!reset_n) begin
      m_hist  = '{1'b1, 1'b1, 1'b1};
      m_f     = 0;
      m_quiet = 0;
      m_d     = 6'b111111;
    end else begin
      ths  = m_hist[1];
      prev = m_hist[2];
      if (SIX) begin
        if (ths != prev) begin
          m_quiet = 0;
          if (!ths) m_f = (m_f % 4) + 1;
        end else begin
          if (m_quiet < T - 1) m_quiet++;
          if (m_quiet == T - 1) m_f = 0;
        end
      end
      m_d = pad_levels(ths, m_f, buttons);
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = th;
    end
  end

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_d(input string name, input logic [5:0] exp);
    checks++;
    if (dut_d !== exp) begin
      errors++;
      $display("FAIL %s: pins got %b expected %b", name, dut_d, exp);
    end
  endtask

  task automatic chk_p(input string name, input logic [2:0] exp);
    checks++;
    if (phase !== exp) begin
      errors++;
      $display("FAIL %s: phase got %0d expected %0d", name, phase, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    clk(n);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        th;
    logic [11:0] btn;
    logic [5:0]  exp;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int hold;
    tbl[0]  = '{1'b1, 12'h000, 6'b111111};
    tbl[1]  = '{1'b1, 12'hFFF, 6'b000000};
    tbl[2]  = '{1'b0, 12'h000, 6'b110011};
    tbl[3]  = '{1'b0, 12'hFFF, 6'b000000};
    tbl[4]  = '{1'b1, 12'h001, 6'b011111};
    tbl[5]  = '{1'b1, 12'h00F, 6'b000011};
    tbl[6]  = '{1'b1, 12'h060, 6'b111100};
    tbl[7]  = '{1'b0, 12'h090, 6'b110000};
    tbl[8]  = '{1'b0, 12'h002, 6'b100011};
    tbl[9]  = '{1'b1, 12'hF00, 6'b111111};
    tbl[10] = '{1'b0, 12'hF10, 6'b110001};

    reset_n = 1'b0; th = 1'b1; buttons = 12'h000;
    clk(2);
    chk_d("reset_pins", 6'b111111);
    chk_p("reset_phase", 3'd0);

    // Each row starts from a fresh reset so at most one fall has been seen.
    for (int i = 0; i < 11; i++) begin
      reset_n = 1'b0;
      clk(1);
      reset_n = 1'b1;
      th = tbl[i].th;
      buttons = tbl[i].btn;
      clk(5);
      chk_d($sformatf("table_%0d", i), tbl[i].exp);
    end

    // Latency: three clocks from th pin, one clock from buttons.
    do_reset(1);
    buttons = 12'h011; th = 1'b1;
    clk(4);
    chk_d("lat_pre", 6'b011111);
    th = 1'b0;
    clk(2);
    chk_d("lat_th_2clk", 6'b011111);
    clk(1);
    chk_d("lat_th_3clk", 6'b010001);
    th = 1'b1;
    clk(4);
    chk_d("lat_high_again", 6'b011111);
    buttons = 12'h000;
    clk(1);
    chk_d("lat_btn_1clk", 6'b111111);

`ifdef JOY_PAD_SIX_BUTTON_EN
    do_reset(1);
    buttons = 12'h800; th = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      th = 1'b1;
      clk(10);
      chk_d($sformatf("six_high_%0d", i), (i == 4) ? 6'b111011 : 6'b111111);
      chk_p($sformatf("six_high_ph_%0d", i), 3'(i - 1));
      th = 1'b0;
      clk(10);
      chk_d($sformatf("six_low_%0d", i), (i == 3) ? 6'b000011 : (i == 4) ? 6'b111111 : 6'b110011);
      chk_p($sformatf("six_low_ph_%0d", i), 3'(i));
    end
    th = 1'b1;
    clk(T - 10);
    chk_p("idle_before_timeout", 3'd4);
    clk(14);
    chk_p("idle_timeout", 3'd0);
    for (int i = 1; i <= 3; i++) begin
      th = 1'b0;
      clk(10);
      if (i == 3) begin
        chk_d("id_after_timeout", 6'b000011);
        chk_p("id_after_timeout_ph", 3'd3);
      end
      th = 1'b1;
      clk(10);
    end
    begin
      int exp_f;
      exp_f = 3;
      for (int k = 0; k < 6; k++) begin
        th = ~th;
        if (!th) exp_f = (exp_f % 4) + 1;
        clk(T - 1);
        chk_p($sformatf("edge_99_%0d", k), 3'(exp_f));
      end
    end
    th = 1'b0;
    clk(10);
    chk_p("pre_reset_f3", 3'd3);
    reset_n = 1'b0;
    clk(1);
    reset_n = 1'b1;
    chk_d("mid_reset_pins", 6'b111111);
    chk_p("mid_reset_phase", 3'd0);
    clk(5);
    chk_p("after_reset_fall", 3'd1);
    chk_d("after_reset_low", 6'b110011);
    for (int i = 0; i < 2; i++) begin
      th = 1'b1;
      clk(10);
      th = 1'b0;
      clk(10);
    end
    chk_d("after_reset_id", 6'b000011);
    chk_p("after_reset_id_ph", 3'd3);
`else
    do_reset(1);
    buttons = 12'hF00; th = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      th = 1'b1;
      clk(10);
      chk_d($sformatf("three_high_%0d", i), 6'b111111);
      th = 1'b0;
      clk(10);
      chk_d($sformatf("three_low_%0d", i), 6'b110011);
      chk_p($sformatf("three_low_ph_%0d", i), 3'd0);
    end
`endif

    do_reset(2);
    hold = 5;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      chk_d($sformatf("rand_pins_%0d", c), m_d);
      chk_p($sformatf("rand_phase_%0d", c), 3'(m_f));
      if (hold == 0) begin
        th = ~th;
        hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 5, T + 10)) : int'($urandom_range(3, 12));
      end else begin
        hold--;
      end
      if ($urandom_range(0, 3) == 0) buttons = 12'($urandom);
      reset_n = ($urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
